// File: rtl/ddr2_read_checker_pkg.sv
// Shared types for the DDR2 read-return checker: error codes, expectation entry, burst length.
// No logic; combinational helper only.
package ddr2_read_checker_pkg;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_DATA     = 3'd1,
        ERR_ADDR     = 3'd2,
        ERR_UNEXP    = 3'd3,
        ERR_TIMEOUT  = 3'd4,
        ERR_OVERFLOW = 3'd5
    } chk_err_e;

    typedef struct packed {
        logic        block;
        logic [1:0]  sz;
        logic [24:0] addr;
    } chk_exp_t;

    // Scalar reads return one word; block reads return 8/16/24/32 words.
    function automatic logic [5:0] chk_len(input logic block, input logic [1:0] sz);
        return block ? ({1'b0, sz, 3'b000} + 6'd8) : 6'd1;
    endfunction

endpackage

// File: rtl/chk_exp_fifo.sv
// Show-ahead expectation FIFO; exposes the head and the entry behind it for same-edge reload.
// Write visible one cycle after push; caller must not push when full unless popping the same cycle.
module chk_exp_fifo
    import ddr2_read_checker_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  logic     pop,
    input  chk_exp_t din,
    output chk_exp_t head,
    output chk_exp_t second,
    output logic     empty,
    output logic     full,
    output logic     two
);

    localparam int AW = $clog2(DEPTH);

    chk_exp_t         mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head   = mem[rd_ptr];
    assign second = mem[rd_ptr + AW'(1)];
    assign empty  = (cnt == '0);
    assign full   = (cnt == (AW+1)'(DEPTH));
    assign two    = (cnt >= (AW+1)'(2));

endmodule

// File: rtl/ddr2_read_checker.sv
// Checks controller read returns against queued expectations (count, address, seeded data).
// Errors/counters registered one cycle after the input; never backpressures, drops pushes when full.
module ddr2_read_checker
    import ddr2_read_checker_pkg::*;
#(
    parameter int          DEPTH       = 16,
    parameter logic [15:0] SEED        = 16'hA5C3,
    parameter int          TIMEOUT_CYC = 2048
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        exp_push,
    input  logic        exp_block,
    input  logic [1:0]  exp_sz,
    input  logic [24:0] exp_addr,
    output logic        exp_full,
    input  logic        validout,
    input  logic [15:0] dout,
    input  logic [24:0] raddr,
    output logic        busy,
    output logic        err_pulse,
    output logic [2:0]  err_code,
    output logic [31:0] words_checked,
    output logic [15:0] err_count,
    output logic [15:0] reads_done
);

    localparam int            TW       = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e        state_q, state_d;
    logic [24:0]   cur_addr_q, cur_addr_d;
    logic [5:0]    rem_q, rem_d;
    logic [TW-1:0] tmo_q, tmo_d;

    chk_exp_t      exp_in, head, second;
    logic          fifo_empty, fifo_full, fifo_two;
    logic          push, pop, ovf, retire, have_ctx;
    logic          word_inc, reads_inc;
    logic [24:0]   eff_addr;
    logic [5:0]    eff_rem;
    chk_err_e      word_err;
    logic [1:0]    n_err;
    logic [16:0]   err_sum;

    assign exp_in = {exp_block, exp_sz, exp_addr};
    // A pop in the same cycle frees the slot before the push is considered.
    assign push   = exp_push && (!fifo_full || pop);
    assign ovf    = exp_push && fifo_full && !pop;

    chk_exp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (exp_in),
        .head    (head),
        .second  (second),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .two     (fifo_two)
    );

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        tmo_d      = tmo_q;
        pop        = 1'b0;
        retire     = 1'b0;
        word_inc   = 1'b0;
        reads_inc  = 1'b0;
        word_err   = ERR_NONE;
        // While IDLE with a queued head, a word is checked straight against the head entry.
        have_ctx   = (state_q == ACTIVE) || !fifo_empty;
        eff_addr   = (state_q == ACTIVE) ? cur_addr_q : head.addr;
        eff_rem    = (state_q == ACTIVE) ? rem_q : chk_len(head.block, head.sz);

        if (validout && !have_ctx) begin
            word_err = ERR_UNEXP;
        end else if (validout) begin
            word_inc = 1'b1;
            if (raddr != eff_addr) begin
                word_err = ERR_ADDR;
            end else if (dout != (raddr[15:0] ^ SEED)) begin
                word_err = ERR_DATA;
            end
            state_d    = ACTIVE;
            cur_addr_d = eff_addr + 25'd1;
            rem_d      = eff_rem - 6'd1;
            tmo_d      = '0;
            if (eff_rem == 6'd1) begin
                retire    = 1'b1;
                reads_inc = 1'b1;
            end
        end else if (state_q == IDLE) begin
            if (!fifo_empty) begin
                state_d    = ACTIVE;
                cur_addr_d = head.addr;
                rem_d      = eff_rem;
                tmo_d      = '0;
            end
        end else if (tmo_q == TMO_LAST) begin
            word_err = ERR_TIMEOUT;
            retire   = 1'b1;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (retire) begin
            pop   = 1'b1;
            tmo_d = '0;
            if (fifo_two) begin
                state_d    = ACTIVE;
                cur_addr_d = second.addr;
                rem_d      = chk_len(second.block, second.sz);
            end else begin
                state_d = IDLE;
            end
        end

        n_err   = {1'b0, (word_err != ERR_NONE)} + {1'b0, ovf};
        err_sum = {1'b0, err_count} + {15'd0, n_err};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cur_addr_q    <= '0;
            rem_q         <= '0;
            tmo_q         <= '0;
            err_pulse     <= 1'b0;
            err_code      <= ERR_NONE;
            words_checked <= '0;
            err_count     <= '0;
            reads_done    <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            rem_q      <= rem_d;
            tmo_q      <= tmo_d;
            err_pulse  <= (word_err != ERR_NONE) || ovf;
            if (word_err != ERR_NONE) begin
                err_code <= word_err;
            end else if (ovf) begin
                err_code <= ERR_OVERFLOW;
            end
            if (word_inc && words_checked != '1) words_checked <= words_checked + 32'd1;
            if (reads_inc && reads_done != '1)   reads_done <= reads_done + 16'd1;
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign busy     = (state_q == ACTIVE) || !fifo_empty;
    assign exp_full = fifo_full;

endmodule

// File: tb/tb_ddr2_read_checker.sv
// Bench for ddr2_read_checker: directed scenarios plus randomized traffic against a read-level model.
module tb_ddr2_read_checker;

    localparam int          DEPTH       = 16;
    localparam logic [15:0] SEED        = 16'hA5C3;
    localparam int          TIMEOUT_CYC = 2048;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        exp_push = 1'b0, exp_block = 1'b0, validout = 1'b0;
    logic [1:0]  exp_sz = '0;
    logic [24:0] exp_addr = '0, raddr = '0;
    logic [15:0] dout = '0;
    logic        exp_full, busy, err_pulse;
    logic [2:0]  err_code;
    logic [31:0] words_checked;
    logic [15:0] err_count, reads_done;

    int n_cmp = 0;
    int n_fail = 0;

    ddr2_read_checker #(.DEPTH(DEPTH), .SEED(SEED), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .reset_n(reset_n),
        .exp_push(exp_push), .exp_block(exp_block), .exp_sz(exp_sz), .exp_addr(exp_addr),
        .exp_full(exp_full), .validout(validout), .dout(dout), .raddr(raddr),
        .busy(busy), .err_pulse(err_pulse), .err_code(err_code),
        .words_checked(words_checked), .err_count(err_count), .reads_done(reads_done)
    );

    always #5 clk = ~clk;

    // Read-level reference: outstanding reads as (first address, word count) plus progress in the head read.
    logic [24:0] q_addr[$];
    int          q_len[$];
    int          m_off;
    logic [31:0] m_words;
    logic [15:0] m_errs, m_reads;
    logic        m_pulse;
    logic [2:0]  m_code;

    function automatic void model_reset();
        q_addr.delete(); q_len.delete();
        m_off = 0; m_words = '0; m_errs = '0; m_reads = '0; m_pulse = 1'b0; m_code = 3'd0;
    endfunction

    function automatic void model_step(input logic p, input logic b, input logic [1:0] s,
                                       input logic [24:0] a, input logic v,
                                       input logic [15:0] d, input logic [24:0] r);
        logic [2:0]  werr = 3'd0;
        logic        ovf  = 1'b0;
        logic [24:0] ea;
        if (v) begin
            if (q_addr.size() == 0) begin
                werr = 3'd3;
            end else begin
                ea = q_addr[0] + 25'(m_off);
                m_words++;
                if (r != ea) werr = 3'd2;
                else if (d != (r[15:0] ^ SEED)) werr = 3'd1;
                m_off++;
                if (m_off == q_len[0]) begin
                    void'(q_addr.pop_front()); void'(q_len.pop_front());
                    m_off = 0;
                    m_reads++;
                end
            end
        end
        if (p) begin
            if (q_addr.size() == DEPTH) ovf = 1'b1;
            else begin
                q_addr.push_back(a);
                q_len.push_back(b ? (int'(s) + 1) * 8 : 1);
            end
        end
        m_pulse = (werr != 3'd0) || ovf;
        if (werr != 3'd0) m_code = werr;
        else if (ovf) m_code = 3'd5;
        m_errs += 16'(int'(werr != 3'd0) + int'(ovf));
    endfunction

    task automatic drive(input logic p, input logic b, input logic [1:0] s, input logic [24:0] a,
                         input logic v, input logic [15:0] d, input logic [24:0] r);
        exp_push = p; exp_block = b; exp_sz = s; exp_addr = a;
        validout = v; dout = d; raddr = r;
        model_step(p, b, s, a, v, d, r);
        @(posedge clk); #1;
        exp_push = 1'b0; validout = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 2'd0, '0, 0, '0, '0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; exp_push = 1'b0; validout = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 7;
        if (words_checked !== 32'd0) begin n_fail++; $display("FAIL reset_words got %0d want 0", words_checked); end
        if (reads_done !== 16'd0) begin n_fail++; $display("FAIL reset_reads got %0d want 0", reads_done); end
        if (err_count !== 16'd0) begin n_fail++; $display("FAIL reset_errs got %0d want 0", err_count); end
        if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %b want 0", err_pulse); end
        if (err_code !== 3'd0) begin n_fail++; $display("FAIL reset_code got %0d want 0", err_code); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (exp_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", exp_full); end
    endtask

    task automatic test_scalar();
        do_reset();
        drive(1, 0, 2'd0, 25'h0000010, 0, '0, '0);
        idle(1);
        drive(0, 0, 2'd0, '0, 1, 16'hA5D3, 25'h0000010);
        n_cmp += 5;
        if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL scalar_pulse got %b want 0", err_pulse); end
        if (words_checked !== 32'd1) begin n_fail++; $display("FAIL scalar_words got %0d want 1", words_checked); end
        if (reads_done !== 16'd1) begin n_fail++; $display("FAIL scalar_reads got %0d want 1", reads_done); end
        if (err_count !== 16'd0) begin n_fail++; $display("FAIL scalar_errs got %0d want 0", err_count); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL scalar_busy got %b want 0", busy); end
    endtask

    task automatic test_block_wrap();
        logic [24:0] a;
        do_reset();
        drive(1, 1, 2'd1, 25'h1FFFFF8, 0, '0, '0);
        for (int i = 0; i < 16; i++) begin
            a = 25'h1FFFFF8 + 25'(i);
            drive(0, 0, 2'd0, '0, 1, a[15:0] ^ SEED, a);
        end
        idle(1);
        n_cmp += 4;
        if (err_count !== 16'd0) begin n_fail++; $display("FAIL block_errs got %0d want 0", err_count); end
        if (reads_done !== 16'd1) begin n_fail++; $display("FAIL block_reads got %0d want 1", reads_done); end
        if (words_checked !== 32'd16) begin n_fail++; $display("FAIL block_words got %0d want 16", words_checked); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL block_busy got %b want 0", busy); end
    endtask

    task automatic test_corrupt();
        logic [24:0] a0, a;
        logic [15:0] d;
        int pulses = 0;
        do_reset();
        a0 = 25'($urandom);
        drive(1, 1, 2'd0, a0, 0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            a = a0 + 25'(i);
            d = a[15:0] ^ SEED;
            if (i == 4) d = d ^ 16'h0008;
            drive(0, 0, 2'd0, '0, 1, d, a);
            if (err_pulse === 1'b1) pulses++;
        end
        idle(1);
        if (err_pulse === 1'b1) pulses++;
        n_cmp += 4;
        if (pulses != 1) begin n_fail++; $display("FAIL corrupt_pulses got %0d want 1", pulses); end
        if (err_code !== 3'd1) begin n_fail++; $display("FAIL corrupt_code got %0d want 1", err_code); end
        if (err_count !== 16'd1) begin n_fail++; $display("FAIL corrupt_errs got %0d want 1", err_count); end
        if (reads_done !== 16'd1) begin n_fail++; $display("FAIL corrupt_reads got %0d want 1", reads_done); end
    endtask

    task automatic test_unexpected();
        do_reset();
        drive(0, 0, 2'd0, '0, 1, 16'h1234, 25'h0000042);
        n_cmp += 3;
        if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL unexp_pulse got %b want 1", err_pulse); end
        if (err_code !== 3'd3) begin n_fail++; $display("FAIL unexp_code got %0d want 3", err_code); end
        if (words_checked !== 32'd0) begin n_fail++; $display("FAIL unexp_words got %0d want 0", words_checked); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) drive(1, 0, 2'd0, 25'(i * 256), 0, '0, '0);
        n_cmp += 2;
        if (exp_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full16 got %b want 1", exp_full); end
        if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL ovf_nopulse got %b want 0", err_pulse); end
        drive(1, 0, 2'd0, 25'h0ABCDE, 0, '0, '0);
        n_cmp += 3;
        if (err_code !== 3'd5) begin n_fail++; $display("FAIL ovf_code got %0d want 5", err_code); end
        if (exp_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", exp_full); end
        if (err_count !== 16'd1) begin n_fail++; $display("FAIL ovf_errs got %0d want 1", err_count); end
        // Retiring the head while pushing into a full queue is accepted.
        drive(1, 0, 2'd0, 25'h0012345, 1, SEED, 25'h0000000);
        n_cmp += 4;
        if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL ovf_pushpop_pulse got %b want 0", err_pulse); end
        if (exp_full !== 1'b1) begin n_fail++; $display("FAIL ovf_pushpop_full got %b want 1", exp_full); end
        if (reads_done !== 16'd1) begin n_fail++; $display("FAIL ovf_pushpop_reads got %0d want 1", reads_done); end
        if (err_count !== 16'd1) begin n_fail++; $display("FAIL ovf_pushpop_errs got %0d want 1", err_count); end
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        drive(1, 0, 2'd0, 25'h0000777, 0, '0, '0);
        while (err_pulse !== 1'b1 && n < TIMEOUT_CYC + 50) begin
            idle(1);
            n++;
        end
        n_cmp += 4;
        if (n != TIMEOUT_CYC + 1) begin n_fail++; $display("FAIL tmo_cycles got %0d want %0d", n, TIMEOUT_CYC + 1); end
        if (err_code !== 3'd4) begin n_fail++; $display("FAIL tmo_code got %0d want 4", err_code); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy got %b want 0", busy); end
        if (reads_done !== 16'd0) begin n_fail++; $display("FAIL tmo_reads got %0d want 0", reads_done); end
    endtask

    task automatic test_back_to_back();
        logic [24:0] ab[2];
        logic [24:0] a;
        do_reset();
        ab[0] = 25'($urandom);
        ab[1] = 25'($urandom);
        drive(1, 1, 2'd0, ab[0], 0, '0, '0);
        drive(1, 1, 2'd0, ab[1], 0, '0, '0);
        for (int i = 0; i < 16; i++) begin
            a = ab[i / 8] + 25'(i % 8);
            drive(0, 0, 2'd0, '0, 1, a[15:0] ^ SEED, a);
        end
        n_cmp += 4;
        if (reads_done !== 16'd2) begin n_fail++; $display("FAIL b2b_reads got %0d want 2", reads_done); end
        if (err_count !== 16'd0) begin n_fail++; $display("FAIL b2b_errs got %0d want 0", err_count); end
        if (words_checked !== 32'd16) begin n_fail++; $display("FAIL b2b_words got %0d want 16", words_checked); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_burst();
        logic [24:0] a;
        do_reset();
        drive(1, 1, 2'd3, 25'h0001000, 0, '0, '0);
        drive(1, 0, 2'd0, 25'h0002000, 0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            a = 25'h0001000 + 25'(i);
            drive(0, 0, 2'd0, '0, 1, (a[15:0] ^ SEED) ^ ((i == 4) ? 16'h0100 : 16'h0000), a);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp += 7;
        if (words_checked !== 32'd0) begin n_fail++; $display("FAIL midrst_words got %0d want 0", words_checked); end
        if (reads_done !== 16'd0) begin n_fail++; $display("FAIL midrst_reads got %0d want 0", reads_done); end
        if (err_count !== 16'd0) begin n_fail++; $display("FAIL midrst_errs got %0d want 0", err_count); end
        if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL midrst_pulse got %b want 0", err_pulse); end
        if (err_code !== 3'd0) begin n_fail++; $display("FAIL midrst_code got %0d want 0", err_code); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        if (exp_full !== 1'b0) begin n_fail++; $display("FAIL midrst_full got %b want 0", exp_full); end
        do_reset();
    endtask

    task automatic test_random();
        logic        p, b, v;
        logic [1:0]  s;
        logic [24:0] a, ra;
        logic [15:0] d;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            p  = ($urandom_range(0, 4) == 0);
            b  = 1'($urandom_range(0, 1));
            s  = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? 25'h1FFFFF0 + 25'($urandom_range(0, 15)) : 25'($urandom);
            ra = 25'($urandom);
            d  = 16'($urandom);
            if (q_addr.size() > 0) begin
                v  = ($urandom_range(0, 3) != 0);
                ra = q_addr[0] + 25'(m_off);
                d  = ra[15:0] ^ SEED;
                if ($urandom_range(0, 15) == 0) d = d ^ 16'(1 << $urandom_range(0, 15));
                if ($urandom_range(0, 31) == 0) ra = ra ^ 25'(1 << $urandom_range(0, 24));
            end else begin
                v = ($urandom_range(0, 15) == 0);
            end
            drive(p, b, s, a, v, d, ra);
            n_cmp += 7;
            if (words_checked !== m_words) begin n_fail++; $display("FAIL rnd_words c=%0d got %0d want %0d", c, words_checked, m_words); end
            if (reads_done !== m_reads) begin n_fail++; $display("FAIL rnd_reads c=%0d got %0d want %0d", c, reads_done, m_reads); end
            if (err_count !== m_errs) begin n_fail++; $display("FAIL rnd_errs c=%0d got %0d want %0d", c, err_count, m_errs); end
            if (err_pulse !== m_pulse) begin n_fail++; $display("FAIL rnd_pulse c=%0d got %b want %b", c, err_pulse, m_pulse); end
            if (err_code !== m_code) begin n_fail++; $display("FAIL rnd_code c=%0d got %0d want %0d", c, err_code, m_code); end
            if (busy !== (q_addr.size() > 0)) begin n_fail++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, q_addr.size() > 0); end
            if (exp_full !== (q_addr.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full c=%0d got %b want %b", c, exp_full, q_addr.size() == DEPTH); end
        end
    endtask

    initial begin
        test_reset();
        test_scalar();
        test_block_wrap();
        test_corrupt();
        test_unexpected();
        test_overflow();
        test_timeout();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
